// File: rtl/periph_bus_arbiter_if.sv
// periph_bus_arbiter_if: two-master request/grant ports plus the shared peripheral bus
interface periph_bus_arbiter_if;
    logic        m0_req;
    logic        m0_rd;
    logic        m0_wr;
    logic [31:0] m0_addr;
    logic [31:0] m0_wdata;
    logic [31:0] m0_rdata;
    logic        m0_gnt;
    logic        m1_req;
    logic        m1_rd;
    logic        m1_wr;
    logic [31:0] m1_addr;
    logic [31:0] m1_wdata;
    logic [31:0] m1_rdata;
    logic        m1_gnt;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [1:0]  owner;

    modport slave (
        input  m0_req, m0_rd, m0_wr, m0_addr, m0_wdata,
        input  m1_req, m1_rd, m1_wr, m1_addr, m1_wdata,
        input  rdata,
        output m0_rdata, m0_gnt, m1_rdata, m1_gnt,
        output rd, wr, addr, wdata, owner
    );

    modport master (
        output m0_req, m0_rd, m0_wr, m0_addr, m0_wdata,
        output m1_req, m1_rd, m1_wr, m1_addr, m1_wdata,
        output rdata,
        input  m0_rdata, m0_gnt, m1_rdata, m1_gnt,
        input  rd, wr, addr, wdata, owner
    );
endinterface

// File: rtl/periph_bus_arbiter.sv
// periph_bus_arbiter: M0-priority arbiter for the peripheral bus with M1 starvation/burst bounds
module periph_bus_arbiter #(
    parameter int unsigned STARVE_LIMIT = 8,
    parameter int unsigned BURST_MAX    = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    periph_bus_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE = 2'b00, OWN_M0 = 2'b01, OWN_M1 = 2'b10} owner_e;

    owner_e     owner_q, owner_d;
    logic [7:0] starve_q, starve_d, burst_q, burst_d, burst_n;
    logic       in_burst_q, in_burst_d, cont, forced;
    logic       sel0, sel1;

    // Next owner; starvation is judged on the count including the M0 grant now ending
    always_comb begin
        starve_d   = (owner_q == OWN_M1) ? 8'd0 :
                     (owner_q == OWN_M0 && bus.m1_req && starve_q != 8'(STARVE_LIMIT)) ? starve_q + 8'd1 :
                     starve_q;
        burst_n    = burst_q + 8'd1;
        cont       = in_burst_q && bus.m1_req && burst_n != 8'(BURST_MAX);
        forced     = bus.m1_req && (starve_d == 8'(STARVE_LIMIT) || cont);
        owner_d    = forced ? OWN_M1 : bus.m0_req ? OWN_M0 : bus.m1_req ? OWN_M1 : IDLE;
        in_burst_d = forced;
        burst_d    = cont ? burst_n : 8'd0;
    end

    // Ownership and fairness state, cleared asynchronously
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner_q    <= IDLE;
            starve_q   <= 8'd0;
            burst_q    <= 8'd0;
            in_burst_q <= 1'b0;
        end else begin
            owner_q    <= owner_d;
            starve_q   <= starve_d;
            burst_q    <= burst_d;
            in_burst_q <= in_burst_d;
        end
    end

    assign sel0         = owner_q == OWN_M0;
    assign sel1         = owner_q == OWN_M1;
    assign bus.m0_gnt   = sel0;
    assign bus.m1_gnt   = sel1;
    assign bus.owner    = owner_q;
    assign bus.rd       = sel0 ? bus.m0_rd : sel1 ? bus.m1_rd : 1'b0;
    assign bus.wr       = sel0 ? bus.m0_wr : sel1 ? bus.m1_wr : 1'b0;
    assign bus.addr     = sel0 ? bus.m0_addr : sel1 ? bus.m1_addr : 32'd0;
    assign bus.wdata    = sel0 ? bus.m0_wdata : sel1 ? bus.m1_wdata : 32'd0;
    assign bus.m0_rdata = sel0 ? bus.rdata : 32'd0;
    assign bus.m1_rdata = sel1 ? bus.rdata : 32'd0;
endmodule
